stream_demux8: RTL
==================

// Module: stream_demux8
// PURPOSE
// - 1-to-8 valid/ready stream demultiplexer; the write-side counterpart of the 8:1 select muxes in the ALU/pipeline datapath.
// - Routes each input beat to the output channel named by in_sel.
// - Each output channel has a one-entry registered holding slot: 1-cycle latency, full throughput per channel.
// - Feeds the per-unit issue queues of the superscalar pipeline from a single dispatch stream.
// PARAMETERS
// - WIDTH  32  data bits per beat
// - CNT_W  16  width of the accepted-beat statistics counter
// PORTS
// - clk          in   1          single clock; all state changes on rising edge
// - rst          in   1          synchronous reset, active-high
// - in_valid     in   1          input beat present
// - in_ready     out  1          demux can accept the beat this cycle
// - in_sel       in   3          destination channel 0..7
// - in_data      in   WIDTH      beat payload
// - out_valid    out  8          bit k: channel k slot holds a beat
// - out_ready    in   8          bit k: channel k consumer accepts this cycle
// - out_data     out  8*WIDTH    channel k payload at [k*WIDTH +: WIDTH]
// - accept_cnt   out  CNT_W      number of input beats accepted since reset
// BEHAVIOUR
// - Reset (sync, active-high): all slot valid flags 0, all slot data 0, accept_cnt 0.
// - While rst is high, in_ready = 0 and out_valid = 0.
// - Reset mid-operation: slot contents are discarded. No beat is accepted in the reset cycle.
// - Input accept: acc = in_valid & in_ready. Output drain: drn[k] = out_valid[k] & out_ready[k].
// - in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]).
//   - Combinational from in_sel and out_ready; no dependence on in_valid.
// - Each slot k is a one-entry pipeline register with 2 states, EMPTY and FULL:
//   - EMPTY, acc to k             -> FULL; data loaded.
//   - FULL, drn[k], no acc to k   -> EMPTY.
//   - FULL, drn[k], acc to k      -> stays FULL; new data loaded in the same edge. This is the simultaneous case: no bubble.
//   - FULL, no drn[k], acc to k   -> impossible, because in_ready = 0.
// - Latency: a beat accepted at edge N is visible on out_valid/out_data at edge N+1 (registered).
// - Ordering: beats to the same channel leave in acceptance order. No ordering is implied across channels.
// - Back-pressure is per channel:
//   - A full, stalled channel blocks only beats addressed to it.
//   - in_sel/in_data must stay stable while in_valid=1 and in_ready=0. The block does not latch them before acceptance.
// - out_data[k] is held stable while out_valid[k]=1 and the beat is not drained. Its value is don't-care when invalid.
// - Non-addressed slots never change on an accept.
// - accept_cnt increments by 1 on every acc and wraps modulo 2^CNT_W (all-ones + 1 -> 0).
// - No combinational path from in_data to out_data.
// STRUCTURE
// - Shared package demux_pkg:
//   - localparam N_OUT = 8, SEL_W = 3.
//   - Function onehot8(sel) returning the 8-bit one-hot decode of sel.
// - Sub-module demux_slot (one per channel, generate loop):
//   - ports clk, rst, load, drain, d[WIDTH], valid, q[WIDTH].
//   - Implements the EMPTY/FULL register described above.
// - Top level: onehot decode of in_sel gated by acc -> load[k]; in_ready mux; accept_cnt register.
// TESTING
// - Reset: drive rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=8'h00, accept_cnt=0; after release, out_valid stays 0 until the first accept.
// - Routing: send sel=0..7 with data 32'hA0..A7, out_ready=8'hFF -> each out_valid[k] pulses 1 cycle later with data A0+k; accept_cnt=8.
// - Back-pressure: out_ready[3]=0, send 2 beats to sel=3 (11, 22) -> first accepted, second sees in_ready=0; sel=5 beat (55) still accepted; release ready -> 11 then 22 on ch3.
// - Simultaneous load+drain: ch2 FULL with 7, out_ready[2]=1, send 9 to ch2 same cycle -> in_ready=1; next cycle out_valid[2]=1, data 9, no bubble.
// - Counter wrap: CNT_W=4, accept 17 beats -> accept_cnt=1.
// - Reset mid-operation: fill ch1 and ch6, assert rst one cycle -> out_valid=0, accept_cnt=0, and the stale beats never reappear.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 stream demultiplexer: channel count,
// select width, the slot state encoding and the channel-select decoder.
package demux_pkg;

  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [N_OUT-1:0] onehot8(input logic [SEL_W-1:0] sel);
    logic [N_OUT-1:0] oh;
    oh      = {N_OUT{1'b0}};
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot for a single output channel.
// A load while full is only legal together with a drain, so the slot refills without a bubble.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state and next-data selection for the EMPTY/FULL slot
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = d;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = d;
        end else if (drain) begin
          state_d = SLOT_EMPTY;
        end else begin
          state_d = SLOT_FULL;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
  end

  // Slot state and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign q     = data_q;

endmodule

// File: rtl/stream_demux8.sv
// 1-to-8 valid/ready stream demultiplexer: each beat goes to the channel named by
// in_sel and is held in that channel's registered slot (1-cycle latency).
module stream_demux8
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       accept_cnt
);

  logic [N_OUT-1:0] slot_valid_s;
  logic [N_OUT-1:0] sel_oh_s;
  logic [N_OUT-1:0] load_s;
  logic [N_OUT-1:0] drain_s;
  logic             acc_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Slots still hold their old flags during the reset cycle; hide them until cleared.
  assign out_valid = slot_valid_s & {N_OUT{~rst}};
  assign in_ready  = ~rst & (~out_valid[in_sel] | out_ready[in_sel]);
  assign acc_s     = in_valid & in_ready;
  assign sel_oh_s  = onehot8(in_sel);
  assign load_s    = sel_oh_s & {N_OUT{acc_s}};
  assign drain_s   = out_valid & out_ready;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load_s[k]),
      .drain(drain_s[k]),
      .d    (in_data),
      .valid(slot_valid_s[k]),
      .q    (out_data[k*WIDTH +: WIDTH])
    );
  end

  // Accepted-beat counter next value, wrapping naturally at 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (acc_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Accepted-beat counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign accept_cnt = cnt_q;

endmodule
